lfsr_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for the 32x32 Dadda multiplier. Programs the seed/mask of an external

---
 rtl/bist_pkg.sv | 32 +++
 rtl/bist_misr.sv | 28 ++
 rtl/lfsr_bist_ctrl.sv | 125 ++++++++++++
 tb/tb_lfsr_bist_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and helpers for the multiplier BIST sequencer: FSM state codes,
// MISR defaults and the MISR next-state function.
package bist_pkg;

  localparam int SIG_W = 64;
  localparam logic [SIG_W-1:0] DEF_SIG_POLY = 64'h1B;
  localparam logic [SIG_W-1:0] DEF_SIG_INIT = 64'h0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FILL_A = 3'd2,
    ST_FILL_B = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_CHECK  = 3'd6,
    ST_SPARE  = 3'd7
  } bist_state_e;

  // Works on the low w bits of a SIG_W-wide container so narrower MISRs share it.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] poly,
                                                 input logic [SIG_W-1:0] din,
                                                 input int               w);
    logic [SIG_W-1:0] keep;
    logic             msb;
    keep = (w >= SIG_W) ? '1 : ((SIG_W'(1) << w) - SIG_W'(1));
    msb  = |(sig & (SIG_W'(1) << (w - 1)));
    misr_next = (((sig << 1) ^ (msb ? poly : '0)) ^ din) & keep;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: folds each enabled product into the
// running signature; clr reloads the initial value for a new test.
module bist_misr
  import bist_pkg::*;
#(
  parameter int             W2   = SIG_W,
  parameter logic [W2-1:0]  POLY = W2'(DEF_SIG_POLY),
  parameter logic [W2-1:0]  INIT = W2'(DEF_SIG_INIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [W2-1:0] din,
  output logic [W2-1:0] sig
);

  logic [SIG_W-1:0] nxt;

  assign nxt = misr_next(SIG_W'(sig), SIG_W'(POLY), SIG_W'(din), W2);

  always_ff @(posedge clk) begin
    if (rst)      sig <= INIT;
    else if (clr) sig <= INIT;
    else if (en)  sig <= nxt[W2-1:0];
  end

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer for the Dadda multiplier: programs the external LFSR, captures
// operand pairs from it, issues them over valid/ready and checks the MISR result.
module lfsr_bist_ctrl
  import bist_pkg::*;
#(
  parameter int               W        = 32,
  parameter int               CW       = 16,
  parameter int               MAX_OUT  = 4,
  parameter logic [2*W-1:0]   SIG_POLY = (2*W)'(DEF_SIG_POLY),
  parameter logic [2*W-1:0]   SIG_INIT = (2*W)'(DEF_SIG_INIT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   seed,
  input  logic [W-1:0]   mask,
  input  logic [CW-1:0]  num_patterns,
  input  logic [2*W-1:0] golden_sig,
  output logic [W-1:0]   lfsr_seed,
  output logic [W-1:0]   lfsr_mask,
  output logic           lfsr_rst,
  input  logic [W-1:0]   lfsr_q,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic           op_valid,
  input  logic           op_ready,
  input  logic [2*W-1:0] prod,
  input  logic           prod_valid,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic           err,
  output logic [2*W-1:0] signature
);

  localparam int OW = $clog2(MAX_OUT + 1);

  bist_state_e    state, state_nxt;
  logic [CW-1:0]  num_q, issued, issued_inc;
  logic [2*W-1:0] golden_q;
  logic [W-1:0]   a_reg, b_reg;
  logic [OW-1:0]  outstanding;
  logic           start_ok, full, accept, prod_ok;

  assign start_ok   = (state == ST_IDLE) && start;
  assign full       = (outstanding == OW'(MAX_OUT));
  // Valid is withheld while the multiplier window is full so a ready from the
  // multiplier can never complete a transfer we are not counting.
  assign op_valid   = (state == ST_ISSUE) && !full;
  assign accept     = op_valid && op_ready;
  assign prod_ok    = prod_valid && (outstanding != '0);
  assign issued_inc = issued + CW'(1);
  assign busy       = (state != ST_IDLE);
  assign lfsr_rst   = (state == ST_LOAD);
  assign op_a       = a_reg;
  assign op_b       = b_reg;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (num_patterns == '0) ? ST_CHECK : ST_LOAD;
      ST_LOAD:   state_nxt = ST_FILL_A;
      ST_FILL_A: state_nxt = ST_FILL_B;
      ST_FILL_B: state_nxt = ST_ISSUE;
      ST_ISSUE:  if (accept) state_nxt = (issued_inc == num_q) ? ST_DRAIN : ST_FILL_A;
      ST_DRAIN:  if (outstanding == '0) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lfsr_seed   <= '0;
      lfsr_mask   <= '0;
      num_q       <= '0;
      golden_q    <= '0;
      issued      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      outstanding <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == ST_CHECK);
      if (start_ok) begin
        lfsr_seed <= seed;
        lfsr_mask <= mask;
        num_q     <= num_patterns;
        golden_q  <= golden_sig;
        pass      <= 1'b0;
      end
      if (state == ST_FILL_A) a_reg <= lfsr_q;
      if (state == ST_FILL_B) b_reg <= lfsr_q;
      if (start_ok)    issued <= '0;
      else if (accept) issued <= issued_inc;
      case ({accept, prod_ok})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase
      if (state == ST_CHECK) pass <= (signature == golden_q);
      // A stray product in the same cycle as start still counts as an error.
      if (prod_valid && (outstanding == '0)) err <= 1'b1;
      else if (start_ok)                     err <= 1'b0;
    end
  end

  bist_misr #(
    .W2   (2 * W),
    .POLY (SIG_POLY),
    .INIT (SIG_INIT)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (prod_ok),
    .din (prod),
    .sig (signature)
  );

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Bench for lfsr_bist_ctrl: external Fibonacci LFSR and in-order multiplier
// models, a cycle-level scoreboard, table-driven runs and corner sequences.
module tb_lfsr_bist_ctrl;

  localparam int          W       = 32;
  localparam int          MAX_OUT = 4;
  localparam logic [63:0] POLY    = 64'h1B;
  localparam logic [31:0] MSK     = 32'h8000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0, mask = '0;
  logic [15:0] num_patterns = '0;
  logic [63:0] golden_sig = '0;
  logic [31:0] lfsr_seed, lfsr_mask, lfsr_q, op_a, op_b;
  logic        lfsr_rst, op_valid, busy, done, pass, err;
  logic        op_ready = 1'b0, prod_valid = 1'b0;
  logic [63:0] prod = '0, signature;

  always #5 clk = ~clk;

  lfsr_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .mask(mask),
    .num_patterns(num_patterns), .golden_sig(golden_sig),
    .lfsr_seed(lfsr_seed), .lfsr_mask(lfsr_mask), .lfsr_rst(lfsr_rst), .lfsr_q(lfsr_q),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .prod(prod), .prod_valid(prod_valid), .busy(busy), .done(done), .pass(pass),
    .err(err), .signature(signature)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] q, input logic [31:0] m);
    return {q[30:0], ^(q & m)};
  endfunction

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input logic [31:0] m, input int k);
    logic [31:0] q;
    q = s;
    for (int i = 0; i < k; i++) q = lfsr_step(q, m);
    return q;
  endfunction

  function automatic logic [63:0] misr_ref(input logic [63:0] s, input logic [63:0] d);
    return (s << 1) ^ (s[63] ? POLY : 64'h0) ^ d;
  endfunction

  // External LFSR: loads the programmed seed on lfsr_rst, free-runs otherwise.
  always @(posedge clk) begin
    if (lfsr_rst) lfsr_q <= lfsr_seed;
    else          lfsr_q <= lfsr_step(lfsr_q, lfsr_mask);
  end

  typedef struct { logic [63:0] p; int due; } pend_t;
  pend_t pq[$];

  int n_chk = 0, n_fail = 0;
  int n = 0, last_due = 0;
  int rdy_mode = 0, lat_mode = 0;
  logic man_rdy = 1'b0, spur = 1'b0;

  logic [31:0] exp_seed, exp_mask;
  logic [15:0] cur_num;
  logic [63:0] cur_golden, exp_sig = '0;
  logic        exp_err = 1'b0;
  logic [31:0] first_a, first_b;
  int load_edge, last_acc, acc_cnt, outst, prods, loads, done_cnt, done_n, start_n;
  logic saw_valid;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // One cycle: drive ready/product for the coming edge and score what that edge does.
  task automatic tick();
    logic pv_ok;
    int   fa, lat, due;
    logic [31:0] ea, eb;
    @(negedge clk);
    n++;
    case (rdy_mode)
      0:       op_ready = 1'b1;
      1:       op_ready = ($urandom_range(0, 3) != 0);
      default: op_ready = man_rdy;
    endcase
    prod_valid = 1'b0;
    if (rst) begin
      pq.delete(); outst = 0; spur = 1'b0;
      return;
    end
    if (spur) begin
      prod_valid = 1'b1; prod = 64'hDEAD_BEEF_0BAD_F00D; spur = 1'b0;
    end else if (pq.size() > 0 && pq[0].due <= n) begin
      prod_valid = 1'b1; prod = pq[0].p; void'(pq.pop_front());
    end
    if (done) begin done_cnt++; done_n = n; end
    if (op_valid) saw_valid = 1'b1;
    if (lfsr_rst) begin
      loads++; load_edge = n;
      check("lfsr_seed", lfsr_seed, exp_seed);
      check("lfsr_mask", lfsr_mask, exp_mask);
    end
    pv_ok = prod_valid && (outst > 0);
    if (prod_valid && !pv_ok) exp_err = 1'b1;
    if (pv_ok) begin exp_sig = misr_ref(exp_sig, prod); outst--; prods++; end
    if (op_valid && op_ready) begin
      fa = (acc_cnt == 0) ? load_edge : last_acc;
      ea = lfsr_adv(exp_seed, exp_mask, fa - load_edge);
      eb = lfsr_step(ea, exp_mask);
      check("op_a", op_a, ea);
      check("op_b", op_b, eb);
      if (acc_cnt == 0) begin first_a = op_a; first_b = op_b; end
      lat = (lat_mode == 0) ? 1 : $urandom_range(1, 6);
      due = (n + lat > last_due) ? n + lat : last_due + 1;
      last_due = due;
      pq.push_back('{p: 64'(ea) * 64'(eb), due: due});
      last_acc = n; acc_cnt++; outst++;
      check("outstanding_bound", 64'(outst <= MAX_OUT), 64'd1);
    end
  endtask

  task automatic begin_test(input logic [31:0] s, input logic [31:0] m,
                            input logic [15:0] num, input logic [63:0] g);
    seed = s; mask = m; num_patterns = num; golden_sig = g;
    exp_seed = s; exp_mask = m; cur_num = num; cur_golden = g;
    exp_sig = 64'h0; exp_err = 1'b0; acc_cnt = 0; prods = 0; loads = 0;
    done_cnt = 0; saw_valid = 1'b0; start_n = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_test();
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin tick(); k++; end
    if (done_cnt == 0) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("sig_model", signature, exp_sig);
      check("pass_model", 64'(pass), 64'(exp_sig == cur_golden));
      check("prod_count", 64'(prods), 64'(cur_num));
      check("lfsr_loads", 64'(loads), 64'(cur_num != 0));
      check("err", 64'(err), 64'(exp_err));
      check("busy_at_done", 64'(busy), 64'd0);
      tick();
      check("done_pulse", 64'(done_cnt), 64'd1);
      check("pass_hold", 64'(pass), 64'(exp_sig == cur_golden));
    end
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!op_valid && k < 50) begin tick(); k++; end
    if (!op_valid) check("op_valid_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [31:0] seed, mask; logic [15:0] num; logic [63:0] golden;
    logic [63:0] exp_sig; logic exp_pass;
  } vec_t;
  vec_t vecs[5];

  initial begin
    logic [31:0] ha, hb;
    logic [63:0] prev_sig;
    vecs[0] = '{seed: 32'd1, mask: MSK, num: 16'd1, golden: 64'h3,     exp_sig: 64'h3,     exp_pass: 1'b1};
    vecs[1] = '{seed: 32'd1, mask: MSK, num: 16'd2, golden: 64'h1D7,   exp_sig: 64'h1D7,   exp_pass: 1'b1};
    vecs[2] = '{seed: 32'd1, mask: MSK, num: 16'd2, golden: 64'h1D6,   exp_sig: 64'h1D7,   exp_pass: 1'b0};
    vecs[3] = '{seed: 32'd1, mask: MSK, num: 16'd0, golden: 64'h0,     exp_sig: 64'h0,     exp_pass: 1'b1};
    vecs[4] = '{seed: 32'd1, mask: MSK, num: 16'd0, golden: 64'h5,     exp_sig: 64'h0,     exp_pass: 1'b0};

    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_op_valid", 64'(op_valid), 64'd0);
    check("rst_flags", {61'd0, done, pass, err}, 64'd0);
    check("rst_signature", signature, 64'h0);
    check("rst_lfsr", {31'd0, lfsr_rst, lfsr_seed}, 64'd0);
    rst = 1'b0;
    tick();

    // Table: T1, T2 (pass and fail goldens), T3 (zero patterns).
    for (int i = 0; i < 5; i++) begin
      rdy_mode = 0; lat_mode = 0;
      begin_test(vecs[i].seed, vecs[i].mask, vecs[i].num, vecs[i].golden);
      finish_test();
      check($sformatf("vec%0d_sig", i), signature, vecs[i].exp_sig);
      check($sformatf("vec%0d_pass", i), 64'(pass), 64'(vecs[i].exp_pass));
      if (vecs[i].num == 0) begin
        check($sformatf("vec%0d_done_lat", i), 64'(done_n - start_n), 64'd2);
        check($sformatf("vec%0d_no_valid", i), 64'(saw_valid), 64'd0);
      end
      if (i == 1) begin
        check("t1_first_a", 64'(first_a), 64'h1);
        check("t1_first_b", 64'(first_b), 64'h3);
      end
    end

    // T4: ready held low in ISSUE keeps the pair steady.
    rdy_mode = 2; man_rdy = 1'b0;
    begin_test(32'd1, MSK, 16'd3, 64'h0);
    wait_valid();
    ha = op_a; hb = op_b;
    check("t4_a_val", 64'(ha), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_valid_hold", 64'(op_valid), 64'd1);
      check("t4_a_hold", 64'(op_a), 64'(ha));
      check("t4_b_hold", 64'(op_b), 64'(hb));
    end
    man_rdy = 1'b1;
    finish_test();

    // Randomised: stalls plus long multiplier latency to fill the window.
    for (int r = 0; r < 10; r++) begin
      rdy_mode = 1; lat_mode = 1;
      begin_test($urandom() | 32'd1, $urandom() | 32'h8000_0000,
                 16'($urandom_range(1, 12)), {$urandom(), $urandom()});
      finish_test();
    end

    // T5: reset in ISSUE aborts without done; restart reproduces T2.
    rdy_mode = 2; man_rdy = 1'b0; lat_mode = 0;
    begin_test(32'd1, MSK, 16'd2, 64'h1D7);
    wait_valid();
    rst = 1'b1;
    tick();
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_op_valid", 64'(op_valid), 64'd0);
    check("t5_signature", signature, 64'h0);
    rst = 1'b0;
    repeat (4) tick();
    check("t5_no_done", 64'(done_cnt), 64'd0);
    rdy_mode = 0;
    begin_test(32'd1, MSK, 16'd2, 64'h1D7);
    finish_test();
    check("t5_restart_sig", signature, 64'h1D7);
    check("t5_restart_pass", 64'(pass), 64'd1);

    // T6: stray product in IDLE, then start while busy is ignored.
    prev_sig = signature;
    spur = 1'b1;
    tick(); tick();
    check("t6_err_set", 64'(err), 64'd1);
    check("t6_sig_kept", signature, prev_sig);
    begin_test(32'd1, MSK, 16'd2, 64'h1D7);
    check("t6_err_clr", 64'(err), 64'd0);
    tick();
    seed = 32'd5; num_patterns = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    finish_test();
    check("t6_sig", signature, 64'h1D7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
